// File: rtl/io_pkg.sv
// Shared definitions for the IO transfer controller family: FSM state encoding,
// counter width helper and default parameter values.
package io_pkg;

   // Controller states, in the order a full load/run/dump sequence visits them.
   typedef enum logic [3:0] {
      StLoad,
      StWr,
      StRun,
      StWaitDump,
      StRd,
      StRdWait,
      StTx,
      StTxWait,
      StDone
   } io_state_e;

   localparam int unsigned DefAddrW    = 16;
   localparam int unsigned DefLoadLen  = 65536;
   localparam int unsigned DefDumpBase = 0;
   localparam int unsigned DefDumpLen  = 65536;
   localparam int unsigned DefRdLat    = 1;
   localparam int unsigned DefAutoDump = 1;
   localparam int unsigned MaxRdLat    = 4;

   // Byte counters carry one extra bit so a length of 2^addr_w terminates
   // without wrapping back to zero.
   function automatic int unsigned cnt_width(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/io_lat_cnt.sv
// Down-counter for fixed memory-latency waits: load starts a LAT-cycle wait,
// expired is high in the last cycle of that wait.
module io_lat_cnt
   import io_pkg::*;
#(
   parameter int unsigned LAT = DefRdLat,
   parameter int unsigned W   = $clog2(MaxRdLat + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic expired
);

   logic [W-1:0] cnt_q;

   // Counter register: reload on request, otherwise count down to zero and hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= W'(LAT);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   // Expiry flag: the cycle holding count 1 is the final wait cycle.
   always_comb begin
      expired = (cnt_q == W'(1));
   end

endmodule

// File: rtl/io_dma_ctrl.sv
// UART <-> memory transfer controller. Loads LOAD_LEN received bytes into the
// shared memory with the CPU held in reset, hands the memory to the CPU, then
// streams the DUMP_BASE/DUMP_LEN window back out over UART.
// All outputs are registered one cycle behind the state that requests them,
// so each strobe lands while its address is already stable.
module io_dma_ctrl
   import io_pkg::*;
#(
   parameter int unsigned ADDR_W    = DefAddrW,
   parameter int unsigned LOAD_LEN  = DefLoadLen,
   parameter int unsigned DUMP_BASE = DefDumpBase,
   parameter int unsigned DUMP_LEN  = DefDumpLen,
   parameter int unsigned RD_LAT    = DefRdLat,
   parameter int unsigned AUTO_DUMP = DefAutoDump
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic              tx_done,
   input  logic              cpu_done,
   input  logic              dump_req,
   output logic              tx_start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic              cpu_reset,
   output logic              sel,
   output logic              overrun,
   output logic              done
);

   localparam int unsigned CntW = cnt_width(ADDR_W);

   localparam logic [CntW-1:0]   LoadLenC  = CntW'(LOAD_LEN);
   localparam logic [CntW-1:0]   DumpLenC  = CntW'(DUMP_LEN);
   localparam logic [ADDR_W-1:0] DumpBaseC = ADDR_W'(DUMP_BASE);

   io_state_e         state_q, state_d;
   logic [CntW-1:0]   wr_cnt_q, wr_cnt_d;
   logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              overrun_q, overrun_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_re_q, mem_re_d;
   logic              tx_start_q, tx_start_d;
   logic              sel_q, sel_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              done_q, done_d;

   logic              lat_load;
   logic              lat_expired;

   io_lat_cnt #(
      .LAT (RD_LAT)
   ) u_lat_cnt (
      .clk     (clk),
      .reset   (reset),
      .load    (lat_load),
      .expired (lat_expired)
   );

   // Latency wait starts as the read strobe is being issued.
   always_comb begin
      lat_load = (state_q == StRd);
   end

   // Next-state, counter and address decode.
   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      addr_d    = addr_q;
      overrun_d = overrun_q;

      case (state_q)
         StLoad: begin
            if (rx_valid) begin
               addr_d  = wr_cnt_q[ADDR_W-1:0];
               state_d = StWr;
            end
         end
         StWr: begin
            // A byte arriving here would overwrite uart_rx's held byte before
            // it is written; it is dropped and flagged.
            if (rx_valid) begin
               overrun_d = 1'b1;
            end
            wr_cnt_d = wr_cnt_q + CntW'(1);
            state_d  = (wr_cnt_d == LoadLenC) ? StRun : StLoad;
         end
         StRun: begin
            if (cpu_done) begin
               state_d = (AUTO_DUMP != 0) ? StRd : StWaitDump;
            end
         end
         StWaitDump: begin
            if (dump_req) begin
               state_d = StRd;
            end
         end
         StRd: begin
            addr_d  = DumpBaseC + rd_cnt_q[ADDR_W-1:0];
            state_d = StRdWait;
         end
         StRdWait: begin
            if (lat_expired) begin
               state_d = StTx;
            end
         end
         StTx: begin
            state_d = StTxWait;
         end
         StTxWait: begin
            if (tx_done) begin
               rd_cnt_d = rd_cnt_q + CntW'(1);
               state_d  = (rd_cnt_d == DumpLenC) ? StDone : StRd;
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StLoad;
         end
      endcase
   end

   // Output decode, registered below.
   always_comb begin
      mem_we_d    = (state_q == StWr);
      mem_re_d    = (state_q == StRd);
      tx_start_d  = (state_q == StTx);
      // sel rises one cycle after RUN entry so the final load write still sees
      // IO ownership, and drops as soon as RUN is left.
      sel_d       = (state_q == StRun) && (state_d == StRun);
      cpu_reset_d = !sel_d;
      done_d      = (state_q == StDone);
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StLoad;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         addr_q      <= '0;
         overrun_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         tx_start_q  <= 1'b0;
         sel_q       <= 1'b0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         addr_q      <= addr_d;
         overrun_q   <= overrun_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         tx_start_q  <= tx_start_d;
         sel_q       <= sel_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
      end
   end

   // Port drive.
   always_comb begin
      tx_start  = tx_start_q;
      mem_addr  = addr_q;
      mem_we    = mem_we_q;
      mem_re    = mem_re_q;
      cpu_reset = cpu_reset_q;
      sel       = sel_q;
      overrun   = overrun_q;
      done      = done_q;
   end

endmodule

// File: tb/tb_io_dma_ctrl.sv
// Scoreboard bench for io_dma_ctrl. Two instances share stimulus: dut_a with
// AUTO_DUMP=1 and dut_m with AUTO_DUMP=0; the idle one is held in reset and a
// mux selects which one the monitor watches.
module tb_io_dma_ctrl;

   localparam int unsigned AW = 4;

   logic clk = 1'b0;
   logic reset_a, reset_m;
   logic rx_valid, tx_done, cpu_done, dump_req;

   logic          a_tx, a_we, a_re, a_crst, a_sel, a_ovr, a_done;
   logic [AW-1:0] a_addr;
   logic          m_tx, m_we, m_re, m_crst, m_sel, m_ovr, m_done;
   logic [AW-1:0] m_addr;

   logic          mon_m;
   logic          mon_tx, mon_we, mon_re, mon_crst, mon_sel, mon_ovr, mon_done;
   logic [AW-1:0] mon_addr;

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      int kind;  // 0 = mem_we, 1 = mem_re, 2 = tx_start
      int addr;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   k;

   io_dma_ctrl #(
      .ADDR_W(AW), .LOAD_LEN(16), .DUMP_BASE(12), .DUMP_LEN(4), .RD_LAT(2), .AUTO_DUMP(1)
   ) dut_a (
      .clk(clk), .reset(reset_a), .rx_valid(rx_valid), .tx_done(tx_done),
      .cpu_done(cpu_done), .dump_req(dump_req), .tx_start(a_tx), .mem_addr(a_addr),
      .mem_we(a_we), .mem_re(a_re), .cpu_reset(a_crst), .sel(a_sel), .overrun(a_ovr),
      .done(a_done)
   );

   io_dma_ctrl #(
      .ADDR_W(AW), .LOAD_LEN(16), .DUMP_BASE(12), .DUMP_LEN(4), .RD_LAT(2), .AUTO_DUMP(0)
   ) dut_m (
      .clk(clk), .reset(reset_m), .rx_valid(rx_valid), .tx_done(tx_done),
      .cpu_done(cpu_done), .dump_req(dump_req), .tx_start(m_tx), .mem_addr(m_addr),
      .mem_we(m_we), .mem_re(m_re), .cpu_reset(m_crst), .sel(m_sel), .overrun(m_ovr),
      .done(m_done)
   );

   assign mon_tx   = mon_m ? m_tx   : a_tx;
   assign mon_we   = mon_m ? m_we   : a_we;
   assign mon_re   = mon_m ? m_re   : a_re;
   assign mon_crst = mon_m ? m_crst : a_crst;
   assign mon_sel  = mon_m ? m_sel  : a_sel;
   assign mon_ovr  = mon_m ? m_ovr  : a_ovr;
   assign mon_done = mon_m ? m_done : a_done;
   assign mon_addr = mon_m ? m_addr : a_addr;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every strobe must match the head of the expectation queue.
   always @(negedge clk) begin
      if (mon_we || mon_re || mon_tx) begin
         k = mon_we ? 0 : (mon_re ? 1 : 2);
         n_chk++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL strobe: got kind=%0d addr=%0d cyc=%0d, required no strobe",
                     k, mon_addr, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k != 2 && e.addr != int'(mon_addr)) || e.cyc != cyc) begin
               n_err++;
               $display("FAIL strobe: got kind=%0d addr=%0d cyc=%0d, required kind=%0d addr=%0d cyc=%0d",
                        k, mon_addr, cyc, e.kind, e.addr, e.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push(input int kind, input int addr, input int c);
      exp_t x;
      x.kind = kind;
      x.addr = addr;
      x.cyc  = c;
      exp_q.push_back(x);
   endtask

   // One received byte; its write lands two cycles after the pulse.
   task automatic rx_byte(input int addr, input int gap);
      rx_valid = 1'b1;
      push(0, addr, cyc + 2);
      tick();
      rx_valid = 1'b0;
      repeat (gap - 1) tick();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " mem_addr"}, int'(mon_addr), 0);
      chk({tag, " strobes"}, int'({mon_we, mon_re, mon_tx}), 0);
      chk({tag, " cpu_reset"}, int'(mon_crst), 1);
      chk({tag, " sel"}, int'(mon_sel), 0);
      chk({tag, " overrun"}, int'(mon_ovr), 0);
      chk({tag, " done"}, int'(mon_done), 0);
   endtask

   // Dump of addresses 12..15; the UART model answers 3 cycles after tx_start,
   // giving an 8-cycle period per byte starting from the trigger cycle c.
   task automatic dump_seq(input bit use_req);
      int c;
      c = cyc;
      if (use_req) dump_req = 1'b1;
      else         cpu_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(1, 12 + i, c + 2 + 8 * i);
         push(2, 0, c + 5 + 8 * i);
      end
      tick();
      dump_req = 1'b0;
      cpu_done = 1'b0;
      chk("dump sel", int'(mon_sel), 0);
      chk("dump cpu_reset", int'(mon_crst), 1);
      for (int i = 0; i < 4; i++) begin
         wait_until(c + 8 + 8 * i);
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
      end
      wait_until(c + 36);
      chk("end done", int'(mon_done), 1);
      chk("end sel", int'(mon_sel), 0);
      chk("end cpu_reset", int'(mon_crst), 1);
   endtask

   initial begin
      reset_a  = 1'b1;
      reset_m  = 1'b1;
      rx_valid = 1'b0;
      tx_done  = 1'b0;
      cpu_done = 1'b0;
      dump_req = 1'b0;
      mon_m    = 1'b0;
      repeat (3) tick();
      chk_reset_vals("reset");

      reset_a = 1'b0;
      repeat (3) tick();

      // Spurious inputs during LOAD.
      tx_done  = 1'b1;
      tick();
      tx_done  = 1'b0;
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      repeat (4) tick();
      chk("spurious load sel", int'(mon_sel), 0);
      chk("spurious load addr", int'(mon_addr), 0);

      // Partial load then reset.
      for (int i = 0; i < 7; i++) rx_byte(i, 10);
      chk("partial addr", int'(mon_addr), 6);
      reset_a = 1'b1;
      tick();
      reset_a = 1'b0;
      chk_reset_vals("mid reset");
      tick();

      // Back-to-back bytes: second dropped, overrun set.
      rx_valid = 1'b1;
      push(0, 0, cyc + 2);
      tick();
      tick();
      rx_valid = 1'b0;
      repeat (8) tick();
      chk("overrun set", int'(mon_ovr), 1);
      chk("overrun still loading", int'(mon_sel), 0);

      for (int i = 1; i < 16; i++) begin
         rx_byte(i, 1);
         if (i == 15) begin
            chk("last wr sel", int'(mon_sel), 0);
            tick();
            tick();
            chk("run sel", int'(mon_sel), 1);
            chk("run cpu_reset", int'(mon_crst), 0);
            chk("run addr no wrap", int'(mon_addr), 15);
         end
         repeat (9) tick();
      end
      chk("overrun sticky", int'(mon_ovr), 1);

      // rx_valid during RUN is ignored.
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      repeat (5) tick();
      chk("run ignore rx sel", int'(mon_sel), 1);
      chk("run ignore rx addr", int'(mon_addr), 15);

      dump_seq(1'b0);
      chk("queue drained a", exp_q.size(), 0);

      // Manual-dump instance; bytes at minimum spacing must not overrun.
      reset_a = 1'b1;
      mon_m   = 1'b1;
      tick();
      reset_m = 1'b0;
      repeat (2) tick();
      for (int i = 0; i < 16; i++) rx_byte(i, 2);
      repeat (3) tick();
      chk("m min spacing overrun", int'(mon_ovr), 0);
      chk("m run sel", int'(mon_sel), 1);
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      repeat (50) tick();
      chk("m wait sel", int'(mon_sel), 0);
      chk("m wait cpu_reset", int'(mon_crst), 1);
      chk("m wait done", int'(mon_done), 0);
      dump_seq(1'b1);
      chk("queue drained m", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
